// File: rtl/mac_chk_pkg.sv
// Shared types and helpers for the mac_8 output checker.
package mac_chk_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 16;
    localparam int unsigned POP_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_e;

    function automatic logic [6:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/chk_sat_counter.sv
// Saturating accumulator with synchronous clear; never wraps past all-ones.
module chk_sat_counter #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned INC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned       SUM_W   = CNT_W + INC_W;
    localparam logic [SUM_W-1:0]  SUM_MAX = SUM_W'({CNT_W{1'b1}});

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [SUM_W-1:0] sum;

    always_comb begin
        sum = SUM_W'(count_q) + SUM_W'(inc);
        if (clr) begin
            count_d = '0;
        end else if (sum > SUM_MAX) begin
            count_d = '1;
        end else begin
            count_d = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mac_8_output_checker.sv
// Compares fabric against benchmark outputs each cycle and reports pass/fail
// after a programmed run.
//   state    | meaning
//   IDLE     | waiting for start, results cleared by reset
//   SKIP     | initialization samples, inputs ignored
//   CHECK    | comparing one sample per cycle
//   DONE     | results frozen until next start
module mac_8_output_checker
    import mac_chk_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned SKIP_CYCLES = 1,
    parameter int unsigned RUN_CYCLES  = 10,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] gfpga_out,
    input  logic [WIDTH-1:0] bench_out,
    input  logic [WIDTH-1:0] bench_dc,
    output logic [WIDTH-1:0] mismatch_flag,
    output logic [WIDTH-1:0] sticky_mask,
    output logic [CNT_W-1:0] nb_error,
    output logic [CNT_W-1:0] first_err_cycle,
    output logic             first_err_valid,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam int unsigned      INC_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(SKIP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);

    if (RUN_CYCLES == 0) begin : g_bad_run_zero
        $error("RUN_CYCLES must be nonzero");
    end
    if (64'(RUN_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_run_len
        $error("RUN_CYCLES exceeds counter range");
    end
    if (64'(SKIP_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_skip_len
        $error("SKIP_CYCLES exceeds counter range");
    end
    if (WIDTH == 0 || WIDTH > POP_MAX_W) begin : g_bad_width
        $error("WIDTH out of supported range");
    end

    chk_state_e       state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [WIDTH-1:0] flag_q, flag_d;
    logic [WIDTH-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0] first_cyc_q, first_cyc_d;
    logic             first_vld_q, first_vld_d;

    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     rise;
    logic [POP_MAX_W-1:0] rise_ext;
    logic                 cnt_clr;
    logic [INC_W-1:0]     cnt_inc;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        flag_d      = flag_q;
        sticky_d    = sticky_q;
        first_cyc_d = first_cyc_q;
        first_vld_d = first_vld_q;
        cnt_clr     = 1'b0;
        cnt_inc     = '0;
        diff        = (gfpga_out ^ bench_out) & ~bench_dc;
        rise        = diff & ~flag_q;
        rise_ext    = '0;
        rise_ext[WIDTH-1:0] = rise;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_clr     = 1'b1;
                    cyc_d       = '0;
                    flag_d      = '0;
                    sticky_d    = '0;
                    first_cyc_d = '0;
                    first_vld_d = 1'b0;
                    state_d     = (SKIP_CYCLES == 0) ? ST_CHECK : ST_SKIP;
                end
            end
            ST_SKIP: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == SKIP_LAST) begin
                    cyc_d   = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                flag_d   = diff;
                sticky_d = sticky_q | diff;
                cnt_inc  = INC_W'(popcount(rise_ext));
                if ((diff != '0) && !first_vld_q) begin
                    first_cyc_d = cyc_q;
                    first_vld_d = 1'b1;
                end
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == RUN_LAST) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            flag_q      <= '0;
            sticky_q    <= '0;
            first_cyc_q <= '0;
            first_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            flag_q      <= flag_d;
            sticky_q    <= sticky_d;
            first_cyc_q <= first_cyc_d;
            first_vld_q <= first_vld_d;
        end
    end

    chk_sat_counter #(
        .CNT_W (CNT_W),
        .INC_W (INC_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (nb_error)
    );

    assign mismatch_flag   = flag_q;
    assign sticky_mask     = sticky_q;
    assign first_err_cycle = first_cyc_q;
    assign first_err_valid = first_vld_q;
    assign busy            = (state_q == ST_SKIP) || (state_q == ST_CHECK);
    assign done            = (state_q == ST_DONE);
    assign pass            = done && (nb_error == '0);

endmodule

// File: tb/tb_mac_8_output_checker.sv
// Scoreboard bench for mac_8_output_checker: per-sample flag expectations and
// per-run final results are queued as stimulus is driven.
module tb_mac_8_output_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start;
    logic [7:0] gfpga_out, bench_out, bench_dc;
    logic [7:0] mismatch_flag, sticky_mask;
    logic [15:0] nb_error, first_err_cycle;
    logic       first_err_valid, busy, done, pass;

    logic       start_s;
    logic [7:0] gfpga_s, bench_s, dc_s;
    logic [7:0] flag_s, sticky_s;
    logic [3:0] nb_s, first_cyc_s;
    logic       first_vld_s, busy_s, done_s, pass_s;

    mac_8_output_checker #(
        .WIDTH(8), .SKIP_CYCLES(1), .RUN_CYCLES(10), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .gfpga_out(gfpga_out), .bench_out(bench_out), .bench_dc(bench_dc),
        .mismatch_flag(mismatch_flag), .sticky_mask(sticky_mask),
        .nb_error(nb_error), .first_err_cycle(first_err_cycle),
        .first_err_valid(first_err_valid), .busy(busy), .done(done), .pass(pass)
    );

    mac_8_output_checker #(
        .WIDTH(8), .SKIP_CYCLES(1), .RUN_CYCLES(16), .CNT_W(4)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s),
        .gfpga_out(gfpga_s), .bench_out(bench_s), .bench_dc(dc_s),
        .mismatch_flag(flag_s), .sticky_mask(sticky_s),
        .nb_error(nb_s), .first_err_cycle(first_cyc_s),
        .first_err_valid(first_vld_s), .busy(busy_s), .done(done_s), .pass(pass_s)
    );

    typedef struct {
        logic [15:0] nb;
        logic [15:0] fc;
        logic        fv;
        logic [7:0]  sticky;
        logic        pass;
    } final_t;

    logic [7:0] exp_flags[$];
    logic [7:0] exp_nb[$];
    final_t     exp_final[$];

    logic [7:0] err_pat [10];
    logic [7:0] dc_pat  [10];
    logic [7:0] skip_err;
    int         start_mid;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pat();
        for (int i = 0; i < 10; i++) begin
            err_pat[i] = 8'h00;
            dc_pat[i]  = 8'h00;
        end
        skip_err  = 8'h00;
        start_mid = -1;
    endtask

    task automatic run_main(input string name, input final_t fexp);
        logic [7:0] ef;
        final_t     f;
        exp_final.push_back(fexp);
        bench_out = 8'($urandom);
        gfpga_out = bench_out;
        bench_dc  = 8'h00;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check_val({name, " busy_skip"}, 32'(busy), 32'd1);
        bench_out = 8'($urandom);
        gfpga_out = bench_out ^ skip_err;
        tick();
        for (int c = 0; c < 10; c++) begin
            check_val($sformatf("%s busy[%0d]", name, c), 32'(busy), 32'd1);
            bench_out = 8'($urandom);
            gfpga_out = bench_out ^ err_pat[c];
            bench_dc  = dc_pat[c];
            start     = (c == start_mid);
            exp_flags.push_back(err_pat[c] & ~dc_pat[c]);
            tick();
            start = 1'b0;
            ef = exp_flags.pop_front();
            check_val($sformatf("%s flag[%0d]", name, c), 32'(mismatch_flag), 32'(ef));
        end
        f = exp_final.pop_front();
        check_val({name, " done"},   32'(done),            32'd1);
        check_val({name, " nb"},     32'(nb_error),        32'(f.nb));
        check_val({name, " fvld"},   32'(first_err_valid), 32'(f.fv));
        check_val({name, " fcyc"},   32'(first_err_cycle), 32'(f.fc));
        check_val({name, " sticky"}, 32'(sticky_mask),     32'(f.sticky));
        check_val({name, " pass"},   32'(pass),            32'(f.pass));
        tick();
        tick();
        check_val({name, " hold_done"}, 32'(done),     32'd1);
        check_val({name, " hold_nb"},   32'(nb_error), 32'(f.nb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] ef, en;
        int         cnt;
        start = 1'b0; gfpga_out = '0; bench_out = '0; bench_dc = '0;
        start_s = 1'b0; gfpga_s = '0; bench_s = '0; dc_s = '0;
        clear_pat();
        #12;
        check_val("rst flag",  32'(mismatch_flag),   32'd0);
        check_val("rst nb",    32'(nb_error),        32'd0);
        check_val("rst fvld",  32'(first_err_valid), 32'd0);
        check_val("rst busy",  32'(busy),            32'd0);
        check_val("rst done",  32'(done),            32'd0);
        check_val("rst pass",  32'(pass),            32'd0);
        check_val("rst_s nb",  32'(nb_s),            32'd0);
        rst_n = 1'b1;

        clear_pat();
        start_mid = 3;
        run_main("clean", '{nb: 16'd0, fc: 16'd0, fv: 1'b0, sticky: 8'h00, pass: 1'b1});

        clear_pat();
        err_pat[4] = 8'h08;
        run_main("glitch", '{nb: 16'd1, fc: 16'd4, fv: 1'b1, sticky: 8'h08, pass: 1'b0});

        clear_pat();
        for (int c = 2; c <= 5; c++) err_pat[c] = 8'h01;
        err_pat[7] = 8'h01;
        run_main("persist", '{nb: 16'd2, fc: 16'd2, fv: 1'b1, sticky: 8'h01, pass: 1'b0});

        clear_pat();
        err_pat[0] = 8'hFF;
        dc_pat[0]  = 8'h0F;
        dc_pat[6]  = 8'hA5;
        run_main("multi_dc", '{nb: 16'd4, fc: 16'd0, fv: 1'b1, sticky: 8'hF0, pass: 1'b0});

        clear_pat();
        skip_err = 8'hFF;
        run_main("skip_only", '{nb: 16'd0, fc: 16'd0, fv: 1'b0, sticky: 8'h00, pass: 1'b1});

        // Reset in the middle of a run that has already recorded an error
        clear_pat();
        bench_out = 8'($urandom); gfpga_out = bench_out; bench_dc = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int c = 0; c <= 5; c++) begin
            bench_out = 8'($urandom);
            gfpga_out = bench_out ^ ((c == 2) ? 8'h30 : 8'h00);
            if (c == 5) begin
                check_val("pre_rst nb", 32'(nb_error), 32'd2);
                rst_n = 1'b0;
                #1;
                check_val("mid_rst flag",   32'(mismatch_flag),   32'd0);
                check_val("mid_rst sticky", 32'(sticky_mask),     32'd0);
                check_val("mid_rst nb",     32'(nb_error),        32'd0);
                check_val("mid_rst fvld",   32'(first_err_valid), 32'd0);
                check_val("mid_rst busy",   32'(busy),            32'd0);
            end else begin
                tick();
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("rst_start busy", 32'(busy), 32'd0);
        check_val("rst_start done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        check_val("post_rst busy", 32'(busy), 32'd0);
        clear_pat();
        run_main("after_rst", '{nb: 16'd0, fc: 16'd0, fv: 1'b0, sticky: 8'h00, pass: 1'b1});

        // Saturation on the 4-bit counter instance
        cnt = 0;
        bench_s = 8'($urandom); gfpga_s = bench_s; dc_s = '0;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        tick();
        for (int c = 0; c < 16; c++) begin
            bench_s = 8'($urandom);
            gfpga_s = bench_s ^ ((c % 2 == 0) ? 8'hFF : 8'h00);
            if (c % 2 == 0) cnt = cnt + 8;
            exp_flags.push_back((c % 2 == 0) ? 8'hFF : 8'h00);
            exp_nb.push_back(8'((cnt > 15) ? 15 : cnt));
            tick();
            ef = exp_flags.pop_front();
            en = exp_nb.pop_front();
            check_val($sformatf("sat flag[%0d]", c), 32'(flag_s), 32'(ef));
            check_val($sformatf("sat nb[%0d]", c),   32'(nb_s),   32'(en));
        end
        check_val("sat done",   32'(done_s),      32'd1);
        check_val("sat nb",     32'(nb_s),        32'd15);
        check_val("sat pass",   32'(pass_s),      32'd0);
        check_val("sat fcyc",   32'(first_cyc_s), 32'd0);
        check_val("sat fvld",   32'(first_vld_s), 32'd1);
        check_val("sat sticky", 32'(sticky_s),    32'hFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
